// File: rtl/wb_writeback.sv
// wb_writeback: MEM->WB writeback stage with a 2-entry result queue.
// Load data is aligned and extended on entry. Each queued result retires
// through the single register-file write port, in order.
// Optional feature macro: WB_FWD_EN adds a combinational forwarding lookup
// port that ID can use to read results still waiting in the queue.
module wb_writeback (
  input  logic        clk_100MHz,
  input  logic        arst_n,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic        mem_rd_we_i,
  input  logic [31:0] mem_result_i,
  input  logic        mem_is_load_i,
  input  logic [2:0]  mem_ld_funct3_i,
  input  logic [1:0]  mem_ld_off_i,
  input  logic [3:0]  hold_i,
  input  logic        flush_i,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]  fwd_raddr_i,
  output logic        fwd_hit_o,
  output logic [31:0] fwd_data_o
`endif
);

  // Queue state: circular pointers, occupancy and per-entry payload.
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [1:0]       we_q, we_d;
  logic [1:0][4:0]  rd_q, rd_d;
  logic [1:0][31:0] data_q, data_d;

  logic        push;
  logic        pop;
  logic [31:0] fmt_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Only the WB hold bit matters here; the lower stages' bits are ignored.
  logic unused_hold;
  assign unused_hold = ^hold_i[2:0];

  // Ready is purely a function of registered occupancy.
  assign mem_ready_o = (count_q != 2'd2);

  assign push = mem_valid_i && mem_ready_o && !flush_i;
  // Reset dominates: no write leaks out while reset is asserted.
  assign pop  = arst_n && (count_q != 2'd0) && !hold_i[3] && !flush_i;

  // Register-file write port driven from the head entry on a retire.
  assign reg_we_o    = pop && we_q[head_q];
  assign reg_waddr_o = reg_we_o ? rd_q[head_q]   : 5'd0;
  assign reg_wdata_o = reg_we_o ? data_q[head_q] : 32'd0;

  // Align and extend load data before it enters the queue.
  always_comb begin
    ld_byte  = mem_result_i[{mem_ld_off_i, 3'b000} +: 8];
    ld_half  = mem_result_i[{mem_ld_off_i[1], 4'b0000} +: 16];
    fmt_data = mem_result_i;
    if (mem_is_load_i) begin
      case (mem_ld_funct3_i)
        3'b000:  fmt_data = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  fmt_data = {24'd0, ld_byte};
        3'b001:  fmt_data = {{16{ld_half[15]}}, ld_half};
        3'b101:  fmt_data = {16'd0, ld_half};
        default: fmt_data = mem_result_i;
      endcase
    end
  end

  // Next-state for pointers, occupancy and entry payloads.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    we_d    = we_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (flush_i) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (push) begin
        for (int i = 0; i < 2; i++) begin
          if (tail_q == i[0]) begin
            // x0 writes are squashed here so retire never has to check rd.
            we_d[i]   = mem_rd_we_i && (mem_rd_addr_i != 5'd0);
            rd_d[i]   = mem_rd_addr_i;
            data_d[i] = fmt_data;
          end
        end
        tail_d = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_100MHz) begin
    if (!arst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      we_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

`ifdef WB_FWD_EN
  logic young_idx;
  logic old_idx;
  assign young_idx = ~tail_q;
  assign old_idx   = tail_q;

  // Forwarding lookup; the younger matching entry overrides the older one.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = 32'd0;
    if (fwd_raddr_i != 5'd0) begin
      if ((count_q == 2'd2) && we_q[old_idx] && (rd_q[old_idx] == fwd_raddr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[old_idx];
      end
      if ((count_q != 2'd0) && we_q[young_idx] && (rd_q[young_idx] == fwd_raddr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[young_idx];
      end
    end
  end
`endif

endmodule
